// File: rtl/alu_mc_pkg.sv
// Shared opcode/state types for the multi-cycle ALU.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_XOR   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_ISZ   = 4'h3,
        OP_NOT   = 4'h4,
        OP_POPC  = 4'h5,
        OP_LT    = 4'h6,
        OP_EQ    = 4'h7,
        OP_MOV   = 4'h8,
        OP_SHIFT = 4'h9,
        OP_ADDI  = 4'hA,
        OP_SUBI  = 4'hB,
        OP_MUL   = 4'hC
    } op_t;

    typedef enum logic {IDLE, RUN} state_t;

    // A zero-distance shift completes in the single-cycle path.
    function automatic logic is_iter(op_t op, logic imm_nz);
        return (op == OP_POPC) || (op == OP_MUL) || ((op == OP_SHIFT) && imm_nz);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative engine for POPC / SHIFT / MUL: one bit per step, next result exposed combinationally.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int W    = 8,
    parameter int IMMW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  op_t             op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [IMMW-1:0] imm,
    output logic            last,
    output logic [W-1:0]    nxt_rslt,
    output logic            nxt_sco
);
    localparam int CNTW = $clog2(W + 1);

    logic [CNTW-1:0] cnt;
    op_t             mode;
    logic            left;
    logic [W-1:0]    sh, mp, sh_n;
    logic [2*W-1:0]  mc, acc, acc_n;
    logic [IMMW:0]   imm_x, mag;

    always_comb begin
        imm_x = {imm[IMMW-1], imm};
        mag   = imm[IMMW-1] ? (~imm_x + 1'b1) : imm_x;
        sh_n  = left ? {sh[W-2:0], 1'b0} : {1'b0, sh[W-1:1]};
        acc_n = acc;
        case (mode)
            OP_POPC: acc_n = acc + (2*W)'(sh[0]);
            OP_MUL:  acc_n = mp[0] ? (acc + mc) : acc;
            default: acc_n = acc;
        endcase
        nxt_rslt = '0;
        nxt_sco  = 1'b0;
        case (mode)
            OP_POPC:  nxt_rslt = acc_n[W-1:0];
            OP_SHIFT: begin
                nxt_rslt = sh_n;
                nxt_sco  = left ? sh[W-1] : sh[0];
            end
            OP_MUL: begin
                nxt_rslt = acc_n[W-1:0];
                nxt_sco  = |acc_n[2*W-1:W];
            end
            default: ;
        endcase
        last = (cnt == CNTW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            mode <= OP_XOR;
            left <= 1'b0;
            sh   <= '0;
            mp   <= '0;
            mc   <= '0;
            acc  <= '0;
        end else if (load) begin
            mode <= op;
            left <= (op == OP_SHIFT) && !imm[IMMW-1];
            sh   <= a;
            mp   <= b;
            mc   <= {{W{1'b0}}, a};
            acc  <= '0;
            cnt  <= (op == OP_SHIFT) ? CNTW'(mag) : CNTW'(W);
        end else if (step) begin
            sh  <= sh_n;
            acc <= acc_n;
            mc  <= mc << 1;
            mp  <= mp >> 1;
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: Start/Done handshake, single-cycle datapath and registered outputs.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int W    = 8,
    parameter int IMMW = 3
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [3:0]      Aluop,
    input  logic [IMMW-1:0] Imm,
    input  logic [W-1:0]    DatA,
    input  logic [W-1:0]    DatB,
    output logic            Busy,
    output logic            Done,
    output logic [W-1:0]    Rslt,
    output logic            SCo,
    output logic            Jen,
    output logic            Zero,
    output logic            Par
);
    state_t       state, state_n;
    op_t          op;
    logic         accept, iter_go, last, nxt_sco, sc_jen;
    logic [W-1:0] nxt_rslt;
    logic [W:0]   sc_sum, zimm;

    assign op      = op_t'(Aluop);
    assign accept  = Start && (state == IDLE);
    assign iter_go = accept && is_iter(op, |Imm);
    assign Busy    = (state == RUN);
    assign Zero    = (Rslt == '0);
    assign Par     = ^Rslt;
    assign zimm    = (W+1)'(Imm);

    // Bit W of sc_sum is the carry/borrow out.
    always_comb begin
        sc_sum = '0;
        sc_jen = 1'b0;
        case (op)
            OP_XOR:   sc_sum = {1'b0, DatA ^ DatB};
            OP_ADD:   sc_sum = {1'b0, DatA} + {1'b0, DatB};
            OP_SUB:   sc_sum = {1'b0, DatA} - {1'b0, DatB};
            OP_ISZ:   sc_sum = (W+1)'(DatA == '0);
            OP_NOT:   sc_sum = {1'b0, ~DatA};
            OP_LT:    sc_jen = (DatA < DatB);
            OP_EQ:    sc_jen = (DatA == DatB);
            OP_MOV:   sc_sum = {1'b0, DatA};
            OP_SHIFT: sc_sum = {1'b0, DatA};
            OP_ADDI:  sc_sum = {1'b0, DatA} + zimm;
            OP_SUBI:  sc_sum = {1'b0, DatA} - zimm;
            default:  ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (iter_go) state_n = RUN;
            RUN:     if (last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Done <= 1'b0;
            Rslt <= '0;
            SCo  <= 1'b0;
            Jen  <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state == RUN && last) begin
                Done <= 1'b1;
                Rslt <= nxt_rslt;
                SCo  <= nxt_sco;
                Jen  <= 1'b0;
            end else if (accept && !iter_go) begin
                Done <= 1'b1;
                Rslt <= sc_sum[W-1:0];
                SCo  <= sc_sum[W];
                Jen  <= sc_jen;
            end
        end
    end

    alu_mc_iter #(.W(W), .IMMW(IMMW)) u_iter (
        .clk      (Clk),
        .rst      (Reset),
        .load     (iter_go),
        .step     (state == RUN),
        .op       (op),
        .a        (DatA),
        .b        (DatB),
        .imm      (Imm),
        .last     (last),
        .nxt_rslt (nxt_rslt),
        .nxt_sco  (nxt_sco)
    );

endmodule
